// File: rtl/serial_digit_alu_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   - Operation codes on the 2-bit mode input (11 behaves as ADD).
//   - FSM state encoding used by the top level.
//   - Helper giving the number of digit cycles per word.
package serial_digit_alu_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_NEG = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit cycles needed for one WIDTH-bit word.
  function automatic int calc_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_digit_alu_digit_adder.sv
// Combinational DIGIT-bit full adder: the generalised 4-bit adder slice.
// Ports:
//   a, b      : DIGIT-bit addends
//   cin       : carry into the least significant bit
//   s         : DIGIT-bit sum
//   cout      : carry out of the most significant bit
//   c_msb_in  : carry into the most significant bit (for overflow detection)
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign s     = w_sum[DIGIT-1:0];
  assign cout  = w_sum[DIGIT];

  // The top sum bit is a ^ b ^ (carry into that bit), so the carry can be
  // recovered without building a second adder.
  assign c_msb_in = a[DIGIT-1] ^ b[DIGIT-1] ^ w_sum[DIGIT-1];

endmodule

// File: rtl/serial_digit_alu.sv
// Digit-serial adder/subtractor for the accumulator path. A WIDTH-bit word
// is processed DIGIT bits per clock, with the carry held in a flip-flop
// between digits. Supports ADD, SUB and NEG with a start/busy/done handshake.
// Ports:
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   start               : operation request, only honoured in IDLE
//   mode                : 00 ADD, 01 SUB, 10 NEG, 11 treated as ADD
//   carry_in            : LSB carry for ADD
//   a, b                : operands, captured when start is accepted
//   busy                : high while digits are being processed
//   done                : one-cycle pulse when result/flags are published
//   result              : result word, held until the next publication
//   carry_out           : MSB carry (SUB: 1 means no borrow)
//   overflow            : two's-complement overflow
//   zero                : result is all zeros
module serial_digit_alu
  import serial_digit_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = calc_digits(WIDTH, DIGIT);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_digit_step;
  logic               w_publish;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_fin;      // every digit processed, result awaiting publication
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_vpend;
  logic               r_busy;

  logic [WIDTH-1:0]   w_ld_a;
  logic [WIDTH-1:0]   w_ld_b;
  logic               w_ld_c;

  logic [DIGIT-1:0]   w_sum_dig;
  logic               w_cout_dig;
  logic               w_cmsb_dig;
  logic [WIDTH+DIGIT-1:0] w_acc_cat;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and FSM outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_accept    = 1'b1;
        end
      end
      RUN: begin
        if (r_fin) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_digit_step = (r_state == RUN) && !r_fin;
  assign w_publish    = (r_state == RUN) && r_fin;
  assign busy         = r_busy;

  // Operand conditioning: subtraction and negation are additions of ~b + 1.
  always_comb begin
    w_ld_a = a;
    w_ld_b = b;
    w_ld_c = carry_in;
    case (mode)
      MODE_SUB: begin
        w_ld_b = ~b;
        w_ld_c = 1'b1;
      end
      MODE_NEG: begin
        w_ld_a = '0;
        w_ld_b = ~b;
        w_ld_c = 1'b1;
      end
      MODE_ADD: ;
      default: ;  // reserved code behaves as ADD
    endcase
  end

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a        (r_opa[DIGIT-1:0]),
    .b        (r_opb[DIGIT-1:0]),
    .cin      (r_carry),
    .s        (w_sum_dig),
    .cout     (w_cout_dig),
    .c_msb_in (w_cmsb_dig)
  );

  // New digit enters at the MSB end; concatenating first keeps this legal
  // when a single digit spans the whole word.
  assign w_acc_cat = {w_sum_dig, r_acc};

  // Digit datapath and published outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_fin     <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_vpend   <= 1'b0;
      r_busy    <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      // busy covers exactly the cycles following a digit step
      r_busy <= w_digit_step;

      if (w_accept) begin
        r_cnt   <= CNT_W'(N - 1);
        r_fin   <= 1'b0;
        r_opa   <= w_ld_a;
        r_opb   <= w_ld_b;
        r_acc   <= '0;
        r_carry <= w_ld_c;
      end else if (w_digit_step) begin
        r_opa   <= r_opa >> DIGIT;
        r_opb   <= r_opb >> DIGIT;
        r_acc   <= w_acc_cat[WIDTH+DIGIT-1:DIGIT];
        r_carry <= w_cout_dig;
        if (r_cnt == '0) begin
          r_fin   <= 1'b1;
          r_vpend <= w_cmsb_dig ^ w_cout_dig;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      if (w_publish) begin
        result    <= r_acc;
        carry_out <= r_carry;
        overflow  <= r_vpend;
        zero      <= (r_acc == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_digit_alu.sv
module tb_serial_digit_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=32, DIGIT=4
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        carry_in = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, carry_out, overflow, zero;
  logic [31:0] result;

  serial_digit_alu #(.WIDTH(32), .DIGIT(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .carry_in(carry_in),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  // Sweep instances: WIDTH=8 with DIGIT=1 and DIGIT=8, sharing stimulus
  logic       s_start = 1'b0;
  logic [1:0] s_mode = 2'b00;
  logic       s_cin = 1'b0;
  logic [7:0] s_a = '0;
  logic [7:0] s_b = '0;
  logic       d1_busy, d1_done, d1_co, d1_v, d1_z;
  logic [7:0] d1_r;
  logic       d8_busy, d8_done, d8_co, d8_v, d8_z;
  logic [7:0] d8_r;

  serial_digit_alu #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(s_start), .mode(s_mode), .carry_in(s_cin),
    .a(s_a), .b(s_b), .busy(d1_busy), .done(d1_done), .result(d1_r),
    .carry_out(d1_co), .overflow(d1_v), .zero(d1_z)
  );

  serial_digit_alu #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .reset(reset), .start(s_start), .mode(s_mode), .carry_in(s_cin),
    .a(s_a), .b(s_b), .busy(d8_busy), .done(d8_done), .result(d8_r),
    .carry_out(d8_co), .overflow(d8_v), .zero(d8_z)
  );

  int checks = 0;
  int failures = 0;

  // Reference: plain modular arithmetic on a w-bit word.
  function automatic void model(input int w, input logic [1:0] m,
                                input logic [63:0] ia, input logic [63:0] ib, input logic ic,
                                output logic [63:0] r, output logic c, output logic v, output logic z);
    logic [63:0] mask;
    logic [63:0] full;
    logic sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    sa = 1'((ia >> (w - 1)) & 64'd1);
    sb = 1'((ib >> (w - 1)) & 64'd1);
    case (m)
      2'b01: begin
        r  = (ia - ib) & mask;
        c  = (ia >= ib);
        sr = 1'((r >> (w - 1)) & 64'd1);
        v  = (sa != sb) && (sr != sa);
      end
      2'b10: begin
        r = (64'd0 - ib) & mask;
        c = (ib == 64'd0);
        v = (ib == (64'd1 << (w - 1)));
      end
      default: begin
        full = ia + ib + {63'd0, ic};
        r    = full & mask;
        c    = 1'((full >> w) & 64'd1);
        sr   = 1'((r >> (w - 1)) & 64'd1);
        v    = (sa == sb) && (sr != sa);
      end
    endcase
    z = (r == 64'd0);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation on the main instance; returns edges from the
  // accepting edge to the done cycle and the number of busy cycles seen.
  task automatic run32(input logic [1:0] m, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; mode = m; a = ia; b = ib; carry_in = ic;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; carry_in = 1'($urandom); mode = 2'($urandom);
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Shared-stimulus operation on both WIDTH=8 instances.
  task automatic op8(input logic [1:0] m, input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     output int lat1, output int lat8,
                     output logic [7:0] r1, output logic [7:0] r8,
                     output logic [2:0] f1, output logic [2:0] f8);
    @(negedge clk);
    s_start = 1'b1; s_mode = m; s_a = ia; s_b = ib; s_cin = ic;
    @(negedge clk);
    s_start = 1'b0; s_a = 8'($urandom); s_b = 8'($urandom); s_cin = 1'($urandom);
    lat1 = -1; lat8 = -1;
    r1 = '0; r8 = '0; f1 = '0; f8 = '0;
    for (int j = 0; j < 40; j++) begin
      if (lat1 < 0 && d1_done === 1'b1) begin
        lat1 = j; r1 = d1_r; f1 = {d1_co, d1_v, d1_z};
      end
      if (lat8 < 0 && d8_done === 1'b1) begin
        lat8 = j; r8 = d8_r; f8 = {d8_co, d8_v, d8_z};
      end
      if (lat1 >= 0 && lat8 >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, carry_out, overflow, zero} !== 5'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state flags=%b result=%h exp flags=00000 result=0",
               {busy, done, carry_out, overflow, zero}, result);
    end
    checks++;
    if ({d1_busy, d1_done, d8_busy, d8_done} !== 4'b0 || d1_r !== 8'd0 || d8_r !== 8'd0) begin
      failures++;
      $display("FAIL reset_state_w8 got d1=%h d8=%h exp 0", d1_r, d8_r);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic dir32(input string nm, input logic [1:0] m, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic [31:0] er, input logic ec, input logic ev, input logic ez);
    int lat, bcnt;
    run32(m, ia, ib, ic, lat, bcnt);
    checks++;
    if (lat !== 9) begin
      failures++; $display("FAIL %s latency got=%0d exp=9", nm, lat);
    end
    checks++;
    if (bcnt !== 8) begin
      failures++; $display("FAIL %s busy_cycles got=%0d exp=8", nm, bcnt);
    end
    checks++;
    if (result !== er) begin
      failures++; $display("FAIL %s result got=%h exp=%h", nm, result, er);
    end
    checks++;
    if ({carry_out, overflow, zero} !== {ec, ev, ez}) begin
      failures++; $display("FAIL %s flags(c,v,z) got=%b exp=%b", nm, {carry_out, overflow, zero}, {ec, ev, ez});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== er) begin
      failures++; $display("FAIL %s hold done=%b result=%h exp done=0 result=%h", nm, done, result, er);
    end
  endtask

  task automatic test_directed;
    dir32("add_5_3",       2'b00, 32'd5,         32'd3,         1'b0, 32'd8,         1'b0, 1'b0, 1'b0);
    dir32("add_wrap",      2'b00, 32'hFFFF_FFFF, 32'd0,         1'b1, 32'd0,         1'b1, 1'b0, 1'b1);
    dir32("add_ovf",       2'b00, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dir32("sub_borrow",    2'b01, 32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    dir32("sub_ovf",       2'b01, 32'h8000_0000, 32'd1,         1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    dir32("neg_1",         2'b10, 32'h1357_9BDF, 32'd1,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    dir32("neg_min",       2'b10, 32'hFFFF_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dir32("neg_0",         2'b10, 32'h0000_00AA, 32'd0,         1'b0, 32'd0,         1'b1, 1'b0, 1'b1);
    dir32("reserved_add",  2'b11, 32'd10,        32'd20,        1'b1, 32'd31,        1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random32;
    int lat, bcnt;
    logic [1:0] m;
    logic [31:0] ia, ib;
    logic ic;
    logic [63:0] er;
    logic ec, ev, ez;
    for (int i = 0; i < 30; i++) begin
      m  = 2'($urandom);
      ia = pick32();
      ib = pick32();
      ic = 1'($urandom);
      model(32, m, {32'd0, ia}, {32'd0, ib}, ic, er, ec, ev, ez);
      run32(m, ia, ib, ic, lat, bcnt);
      checks++;
      if (lat !== 9 || result !== er[31:0] || {carry_out, overflow, zero} !== {ec, ev, ez}) begin
        failures++;
        $display("FAIL rand32[%0d] m=%b a=%h b=%h ci=%b got lat=%0d r=%h cvz=%b exp lat=9 r=%h cvz=%b",
                 i, m, ia, ib, ic, lat, result, {carry_out, overflow, zero}, er[31:0], {ec, ev, ez});
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    // Start pulse during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; a = 32'h1234_5678; b = 32'h0101_0101; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b1; mode = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 9 || result !== 32'h1335_5779 || {carry_out, overflow} !== 2'b00) begin
      failures++;
      $display("FAIL start_in_run got lat=%0d r=%h cv=%b exp lat=9 r=13355779 cv=00",
               lat, result, {carry_out, overflow});
    end
    // Start raised in the done cycle: ignored there, accepted one edge later in IDLE.
    start = 1'b1; mode = 2'b01; a = 32'd1000; b = 32'd1; carry_in = 1'b0;
    lat = 0;
    @(negedge clk); lat++;
    @(negedge clk); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 11 || result !== 32'd999 || {carry_out, overflow, zero} !== 3'b100) begin
      failures++;
      $display("FAIL start_in_done got lat=%0d r=%h cvz=%b exp lat=11 r=%h cvz=100",
               lat, result, {carry_out, overflow, zero}, 32'd999);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; a = 32'd77; b = 32'd88; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, carry_out, overflow, zero} !== 5'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_run flags=%b result=%h exp flags=00000 result=0",
               {busy, done, carry_out, overflow, zero}, result);
    end
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++; $display("FAIL reset_no_done activity_cycles got=%0d exp=0", dones);
    end
    dir32("add_after_reset", 2'b00, 32'd1234, 32'd4321, 1'b1, 32'd5556, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sweep;
    int lat1, lat8;
    logic [7:0] r1, r8;
    logic [2:0] f1, f8;
    logic [1:0] m;
    logic [7:0] ia, ib;
    logic ic;
    logic [63:0] er;
    logic ec, ev, ez;
    op8(2'b00, 8'd200, 8'd100, 1'b0, lat1, lat8, r1, r8, f1, f8);
    checks++;
    if (lat1 !== 9 || r1 !== 8'd44 || f1[2] !== 1'b1) begin
      failures++; $display("FAIL sweep_d1 got lat=%0d r=%0d c=%b exp lat=9 r=44 c=1", lat1, r1, f1[2]);
    end
    checks++;
    if (lat8 !== 2 || r8 !== 8'd44 || f8[2] !== 1'b1) begin
      failures++; $display("FAIL sweep_d8 got lat=%0d r=%0d c=%b exp lat=2 r=44 c=1", lat8, r8, f8[2]);
    end
    for (int i = 0; i < 12; i++) begin
      m  = 2'($urandom);
      ia = 8'($urandom);
      ib = (i % 4 == 0) ? 8'h80 : 8'($urandom);
      ic = 1'($urandom);
      model(8, m, {56'd0, ia}, {56'd0, ib}, ic, er, ec, ev, ez);
      op8(m, ia, ib, ic, lat1, lat8, r1, r8, f1, f8);
      checks++;
      if (lat1 !== 9 || lat8 !== 2 || r1 !== er[7:0] || r8 !== er[7:0] ||
          f1 !== {ec, ev, ez} || f8 !== {ec, ev, ez}) begin
        failures++;
        $display("FAIL sweep_rand[%0d] m=%b a=%h b=%h ci=%b got lat=%0d/%0d r=%h/%h cvz=%b/%b exp lat=9/2 r=%h cvz=%b",
                 i, m, ia, ib, ic, lat1, lat8, r1, r8, f1, f8, er[7:0], {ec, ev, ez});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random32();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_digit_alu.md
Name: serial_digit_alu

Overview:
- Parametrised digit-serial adder/subtractor for the Baby datapath; successor to the 4-bit parallel adder slice.
- Processes a WIDTH-bit word DIGIT bits per clock, with the carry held in a flip-flop between digits.
- Supports the ADD, SUB and NEG operations the accumulator path needs, with a start/busy/done handshake to the control sequencer.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; legal values are 1, 2, 4 and 8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- mode  input  2  00 ADD, 01 SUB, 10 NEG, 11 reserved.
- carry_in  input  1  carry into the LSB digit; used by ADD only.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- carry_out  output  1  carry out of the MSB; for SUB, 1 means no borrow (A >= B unsigned).
- overflow  output  1  two's-complement overflow.
- zero  output  1  result equals 0.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset: state IDLE; busy, done, result, carry_out, overflow and zero all 0. Shift registers and the carry flip-flop are cleared.
- N = WIDTH/DIGIT digit cycles per operation.
- States:
  - IDLE -> RUN on start=1 at an edge. At that edge: capture a and b into shift registers, load the digit counter with N-1, and load the carry flip-flop.
  - RUN: one digit per cycle. After the last digit -> DONE.
  - DONE: lasts one cycle with done=1, then -> IDLE.
- Operand and carry load per mode:
  - ADD: opA=a, opB=b, c0=carry_in.
  - SUB: opA=a, opB=~b, c0=1.
  - NEG: opA=0, opB=~b, c0=1.
  - 11: treated as ADD.
- RUN cycle:
  - digit sum = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - The sum digit enters the result shift register at the MSB end; opA and opB shift right by DIGIT.
  - The carry flip-flop takes the digit carry-out.
- Final digit: latch carry_out = final digit carry. Latch overflow = (carry into MSB bit) XOR (carry out of MSB bit). zero is computed from the complete result.
- Timing: start accepted at edge k. RUN occupies the cycles after edges k+1..k+N. done=1 and busy=0 in the cycle after edge k+N+1. busy=1 from edge k+1 through edge k+N+1.
- Flags and result update only when done rises; they are stable between operations.
- start while busy (RUN or DONE) is ignored, with no queuing. start in the same cycle as done is ignored. start asserted in IDLE after done is accepted.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- Reset asserted mid-RUN: return to IDLE next edge, clear all outputs, no done pulse. Reset has priority over start.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Package serial_digit_alu_pkg holds:
  - mode constants MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_NEG=2'b10;
  - state encoding IDLE/RUN/DONE;
  - a function computing N from WIDTH and DIGIT.
- Sub-module digit_adder: combinational DIGIT-wide full adder, the generalised 4-bit slice.
  - Inputs: a, b, cin.
  - Outputs: s, cout, c_msb_in (carry into its top bit, used for overflow).
- The top level holds the FSM, digit counter, shift registers and flag logic.

Test Plan (WIDTH=32, DIGIT=4, N=8 unless stated):
- ADD a=5, b=3, carry_in=0 -> done exactly 9 edges after the accepting edge; result=8, carry_out=0, overflow=0, zero=0; busy high for 8 cycles.
- ADD a=0xFFFFFFFF, b=0, carry_in=1 -> result=0, carry_out=1, zero=1, overflow=0. ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1.
- SUB a=3, b=5 -> result=0xFFFFFFFE, carry_out=0, overflow=0. SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, carry_out=1, overflow=1.
- NEG b=1 -> result=0xFFFFFFFF. NEG b=0x80000000 -> result=0x80000000, overflow=1. NEG b=0 -> result=0, zero=1, carry_out=1.
- Second start pulsed at RUN cycle 3 with different operands -> ignored, first result delivered unchanged. Reset asserted at RUN cycle 4 -> next cycle busy=0 and outputs=0, no done pulse; a fresh ADD afterwards completes correctly.
- Parameter sweep WIDTH=8, DIGIT=1: ADD a=200, b=100 -> result=44 and carry_out=1 after 8 digit cycles. WIDTH=8, DIGIT=8 (N=1): same result with done 2 edges after the accepting edge.
